// File: rtl/sync_data_memory.sv
// Single-port word memory with byte enables, 1-cycle registered reads
// and a post-reset zeroing sweep that holds ready low until it completes.
module sync_data_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic                    wn,
  input  logic                    rd,
  output logic [DATA_WIDTH-1:0]   read_data,
  output logic                    rvalid,
  output logic                    ready,
  output logic                    err
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  typedef enum logic {
    INIT,
    IDLE
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic          in_range;
  logic          acc_wn;
  logic          acc_rd;
  logic [CW-1:0] idx;

  // Full-width compare: out-of-range addresses never alias into the array.
  assign in_range = {1'b0, address} < DEPTH_L;
  assign idx      = address[CW-1:0];
  assign ready    = (state_q == IDLE);
  assign acc_wn   = ready & wn;
  assign acc_rd   = ready & rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        cnt_d = '0;
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Non-blocking update gives read-before-write on a same-address collision.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem[cnt_q] <= '0;
    end else if (acc_wn && in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= write_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = acc_rd;
    err_d    = (acc_rd | acc_wn) & ~in_range;
    if (acc_rd) rdata_d = in_range ? mem[idx] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  assign read_data = rdata_q;
  assign rvalid    = rvalid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sync_data_memory.sv
// Directed bench for sync_data_memory (32-bit words, 16-bit address,
// 16 words): init sweep, byte enables, read-before-write, range errors.
module tb_sync_data_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] address;
  logic [31:0] write_data;
  logic [3:0]  be;
  logic        wn;
  logic        rd;
  logic [31:0] read_data;
  logic        rvalid;
  logic        ready;
  logic        err;

  int ncmp = 0;
  int nerr = 0;
  int wait_cnt;

  logic [31:0] expw [16];

  sync_data_memory #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(16),
    .DEPTH     (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .address   (address),
    .write_data(write_data),
    .be        (be),
    .wn        (wn),
    .rd        (rd),
    .read_data (read_data),
    .rvalid    (rvalid),
    .ready     (ready),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    wait_cnt = 0;
    while (!ready && wait_cnt < 100) begin
      step();
      wait_cnt++;
      if (!ready) begin
        chk({tag, "_rvalid"}, {31'd0, rvalid}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
      end
    end
    chk({tag, "_cycles"}, wait_cnt, 32'd16);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d,
                    input logic [3:0] b);
    address = a; write_data = d; be = b; wn = 1'b1; rd = 1'b0;
    step();
    wn = 1'b0;
  endtask

  initial begin
    rst = 1'b1; address = '0; write_data = '0; be = '0;
    wn = 1'b0; rd = 1'b0;
    step();
    step();
    chk("rst_rdata", read_data, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);

    // Requests during the sweep must be ignored.
    rst = 1'b0;
    address = 16'd2; write_data = 32'h55; be = 4'hF;
    wn = 1'b1; rd = 1'b1;
    wait_ready("init");
    wn = 1'b0; rd = 1'b0;

    for (int i = 0; i < 16; i++) begin
      address = 16'(i); rd = 1'b1;
      step();
      chk($sformatf("init_rd%0d", i), read_data, 32'd0);
      chk($sformatf("init_rv%0d", i), {31'd0, rvalid}, 32'd1);
    end
    rd = 1'b0;
    step();
    chk("init_rv_drop", {31'd0, rvalid}, 32'd0);

    // Reset at sweep count 7 restarts the full sweep.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("mid_ready", {31'd0, ready}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_ready("resweep");

    for (int i = 0; i < 16; i++) expw[i] = 32'd0;

    wr(16'd0, 32'h0, 4'hF);  expw[0] = 32'h0;
    wr(16'd1, 32'h1, 4'hF);  expw[1] = 32'h1;
    wr(16'd2, 32'h10, 4'hF); expw[2] = 32'h10;
    wr(16'd3, 32'h6, 4'hF);  expw[3] = 32'h6;
    wr(16'd4, 32'h12, 4'hF); expw[4] = 32'h12;
    chk("wr_no_rvalid", {31'd0, rvalid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      address = 16'(i); rd = 1'b1;
      step();
      chk($sformatf("wb_rd%0d", i), read_data, expw[i]);
      chk($sformatf("wb_rv%0d", i), {31'd0, rvalid}, 32'd1);
    end
    rd = 1'b0;
    step();
    chk("hold_rv", {31'd0, rvalid}, 32'd0);
    chk("hold_rdata", read_data, 32'h12);
    step();
    chk("hold_rdata2", read_data, 32'h12);

    wr(16'd5, 32'hAABBCCDD, 4'hF);
    wr(16'd5, 32'h11223344, 4'b0101);
    expw[5] = 32'hAA22CC44;
    address = 16'd5; rd = 1'b1;
    step();
    rd = 1'b0;
    chk("be_rd", read_data, 32'hAA22CC44);

    wr(16'd6, 32'h12345678, 4'hF);
    address = 16'd6; write_data = 32'hDEADBEEF; be = 4'hF;
    wn = 1'b1; rd = 1'b1;
    step();
    wn = 1'b0;
    chk("rbw_old", read_data, 32'h12345678);
    chk("rbw_rv", {31'd0, rvalid}, 32'd1);
    step();
    rd = 1'b0;
    chk("rbw_new", read_data, 32'hDEADBEEF);
    expw[6] = 32'hDEADBEEF;

    wr(16'd16, 32'hFFFFFFFF, 4'hF);
    chk("oor_wr_err", {31'd0, err}, 32'd1);
    chk("oor_wr_rv", {31'd0, rvalid}, 32'd0);
    step();
    chk("oor_wr_err_off", {31'd0, err}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      address = 16'(i); rd = 1'b1;
      step();
      chk($sformatf("oor_chk%0d", i), read_data, expw[i]);
    end
    chk("oor_chk_err", {31'd0, err}, 32'd0);

    address = 16'hFFFF; rd = 1'b1;
    step();
    rd = 1'b0;
    chk("oor_rd_data", read_data, 32'd0);
    chk("oor_rd_rv", {31'd0, rvalid}, 32'd1);
    chk("oor_rd_err", {31'd0, err}, 32'd1);
    step();
    chk("oor_rd_err_off", {31'd0, err}, 32'd0);

    address = 16'd16; write_data = 32'h0; wn = 1'b1; rd = 1'b1;
    step();
    wn = 1'b0; rd = 1'b0;
    chk("oor_both_err", {31'd0, err}, 32'd1);
    step();
    chk("oor_both_once", {31'd0, err}, 32'd0);

    // A read coinciding with reset must not produce rvalid.
    address = 16'd4; rd = 1'b1;
    step();
    chk("pre_rst_rd", read_data, 32'h12);
    rst = 1'b1;
    step();
    rd = 1'b0;
    chk("rst_rd_rv", {31'd0, rvalid}, 32'd0);
    chk("rst_rd_data", read_data, 32'd0);
    chk("rst_rd_ready", {31'd0, ready}, 32'd0);
    rst = 1'b0;
    step();
    chk("rst_rd_rv2", {31'd0, rvalid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
